axis_video_to_par_video_tgen: RTL

// - Streaming successor to the AXI4-Stream-video-to-parallel-video bridge.
// - Buffers AXI4-Stream video pixels in an internal FIFO and locks to start-of-frame (tuser).
// - Replays pixels on a parallel bus with generated hsync/vsync/de timing; every timing field is parameterised.
// - Detects underflow and frame misalignment, then resynchronises on the next tuser.
// - Sits between the video DMA/AXIS pipeline and the display PHY.
//

---
 rtl/axis_vid_pkg.sv | 18 +
 rtl/axis_vid_fifo.sv | 51 +++++
 rtl/axis_video_to_par_video_tgen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/axis_vid_pkg.sv
// Shared types and helpers for the AXIS-video to parallel-video timing generator.
package axis_vid_pkg;

  typedef enum logic [1:0] {SeekSof, Fill, Run} fsm_t;

  // One axis (horizontal or vertical) of video timing, regions in scan order.
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vid_timing_t;

  function automatic int unsigned total(input vid_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/axis_vid_fifo.sv
// First-word-fall-through pixel FIFO; head_o shows the oldest entry whenever !empty_o.
module axis_vid_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 34
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (level_q == (AW+1)'(DEPTH));
    empty_o = (level_q == '0);
    do_pop  = pop_i && !empty_o;
    // A pop frees the slot this cycle, so push-at-full with pop keeps the level.
    do_push = push_i && (!full_o || do_pop);
    level_o = level_q;
    head_o  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/axis_video_to_par_video_tgen.sv
// Buffers AXIS video, locks to tuser and replays pixels with generated hsync/vsync/de timing.
module axis_video_to_par_video_tgen
  import axis_vid_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned PAR_VIDEO_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH           = 16,
  parameter int unsigned START_LEVEL          = 8,
  parameter int unsigned H_ACTIVE             = 1920,
  parameter int unsigned H_FP                 = 88,
  parameter int unsigned H_SYNC               = 44,
  parameter int unsigned H_BP                 = 148,
  parameter int unsigned V_ACTIVE             = 1080,
  parameter int unsigned V_FP                 = 4,
  parameter int unsigned V_SYNC               = 5,
  parameter int unsigned V_BP                 = 36,
  parameter bit          HSYNC_POL            = 1'b1,
  parameter bit          VSYNC_POL            = 1'b1
) (
  input  logic                            i_aclk,
  input  logic                            i_aresetn,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] i_s_axis_video_tdata,
  input  logic                            i_s_axis_video_tvalid,
  output logic                            o_s_axis_video_tready,
  input  logic                            i_s_axis_video_tlast,
  input  logic                            i_s_axis_video_tuser,
  output logic [PAR_VIDEO_DATA_WIDTH-1:0] o_par_video_data,
  output logic                            o_par_video_de,
  output logic                            o_par_video_hsync,
  output logic                            o_par_video_vsync,
  output logic                            o_underflow,
  output logic                            o_misalign
);

  localparam int unsigned TW = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned PW = PAR_VIDEO_DATA_WIDTH;
  localparam int unsigned EW = TW + 2;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  localparam vid_timing_t HTim = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vid_timing_t VTim = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned HTotal = total(HTim);
  localparam int unsigned VTotal = total(VTim);
  localparam int unsigned HW = $clog2(HTotal);
  localparam int unsigned VW = $clog2(VTotal);

  localparam logic [HW-1:0] HActive    = HW'(HTim.active);
  localparam logic [HW-1:0] HActLast   = HW'(HTim.active - 1);
  localparam logic [HW-1:0] HSyncStart = HW'(HTim.active + HTim.fp);
  localparam logic [HW-1:0] HSyncEnd   = HW'(HTim.active + HTim.fp + HTim.sync);
  localparam logic [HW-1:0] HLast      = HW'(HTotal - 1);
  localparam logic [VW-1:0] VActive    = VW'(VTim.active);
  localparam logic [VW-1:0] VSyncStart = VW'(VTim.active + VTim.fp);
  localparam logic [VW-1:0] VSyncEnd   = VW'(VTim.active + VTim.fp + VTim.sync);
  localparam logic [VW-1:0] VLast      = VW'(VTotal - 1);
  localparam logic [LW-1:0] StartLvl   = LW'(START_LEVEL);

  fsm_t            state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic            rdy_en_q;
  logic [PW-1:0]   data_q, data_d;
  logic            de_q, de_d, hs_q, hs_d, vs_q, vs_d, uf_q, uf_d, ma_q, ma_d;

  logic            fifo_full, fifo_empty, push, pop, tready;
  logic [LW-1:0]   fifo_level;
  logic [EW-1:0]   head;
  logic            head_user, head_last;
  logic [TW-1:0]   head_data;
  logic            origin, active, seek_pop, timing_on;

  assign head_user = head[EW-1];
  assign head_last = head[EW-2];
  assign head_data = head[TW-1:0];

  axis_vid_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk_i  (i_aclk),
    .rst_ni (i_aresetn),
    .push_i (push),
    .data_i ({i_s_axis_video_tuser, i_s_axis_video_tlast, i_s_axis_video_tdata}),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level),
    .head_o (head)
  );

  always_comb begin
    origin   = (h_q == '0) && (v_q == '0);
    active   = (h_q < HActive) && (v_q < VActive);
    seek_pop = (state_q == SeekSof) && !fifo_empty && !head_user;
    // While seeking, stay ready except when a parked SOF leaves no room (would drop beats).
    if (state_q == SeekSof) tready = rdy_en_q && (!fifo_full || seek_pop);
    else                    tready = rdy_en_q && !fifo_full;
    push      = i_s_axis_video_tvalid && tready;
    state_d   = state_q;
    pop       = seek_pop;
    timing_on = 1'b0;
    de_d      = 1'b0;
    data_d    = '0;
    uf_d      = 1'b0;
    ma_d      = 1'b0;
    unique case (state_q)
      SeekSof: begin
        // Off-origin counters mean an aborted frame is still being timed out with blank data.
        timing_on = !origin;
        de_d      = active && !origin;
        if (origin && !fifo_empty && head_user) state_d = Fill;
      end
      Fill: begin
        if (fifo_level >= StartLvl) state_d = Run;
      end
      Run: begin
        timing_on = 1'b1;
        de_d      = active;
        if (active) begin
          if (fifo_empty) begin
            uf_d    = 1'b1;
            state_d = SeekSof;
          end else begin
            pop    = 1'b1;
            data_d = PW'(head_data);
            if ((head_user != origin) || (head_last && (h_q != HActLast))) begin
              ma_d    = 1'b1;
              state_d = SeekSof;
            end
          end
        end
      end
      default: state_d = SeekSof;
    endcase
    h_d = h_q;
    v_d = v_q;
    if (timing_on) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    hs_d = (timing_on && (h_q >= HSyncStart) && (h_q < HSyncEnd)) ? HSYNC_POL : ~HSYNC_POL;
    vs_d = (timing_on && (v_q >= VSyncStart) && (v_q < VSyncEnd)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q  <= SeekSof;
      h_q      <= '0;
      v_q      <= '0;
      rdy_en_q <= 1'b0;
      data_q   <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~HSYNC_POL;
      vs_q     <= ~VSYNC_POL;
      uf_q     <= 1'b0;
      ma_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      rdy_en_q <= 1'b1;
      data_q   <= data_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      uf_q     <= uf_d;
      ma_q     <= ma_d;
    end
  end

  assign o_s_axis_video_tready = tready;
  assign o_par_video_data      = data_q;
  assign o_par_video_de        = de_q;
  assign o_par_video_hsync     = hs_q;
  assign o_par_video_vsync     = vs_q;
  assign o_underflow           = uf_q;
  assign o_misalign            = ma_q;

endmodule
